rob_commit: RTL and testbench
=============================

// Module: rob_commit
// PURPOSE
//   Reorder buffer and in-order commit unit: the consumer of the rename bundle and the producer
//   of the commit bundle. Accepts renamed ops via the per-slot rename handshake and tracks their
//   completion. Retires them in order and emits com_bundle: preg deallocation, branch-snapshot
//   redirect, or a youngest-first rollback walk that restores the map table and free list.
// PARAMETERS
//   rwd    4   rename width (slots accepted per cycle)
//   cwd    4   commit width (slots retired or rolled back per cycle)
//   wbw    4   writeback/completion ports
//   robsz  32  ROB entries, power of two, >= rwd
// PORTS
//   clk         in   1              clock
//   rst         in   1              asynchronous reset, active-low
//   ren_bundle  in   ren_bundle_t[rwd]  renamed ops; slot valid = opid[15]
//   ren_lrda    in   [rwd][7]       logical destination register per slot
//   rename      out  [rwd]          accept per slot (pops the rename queue)
//   rob_idx     out  [rwd][log2(robsz)]  ROB index given to each accepted slot
//   wb_valid    in   [wbw]          completion strobe
//   wb_idx      in   [wbw][log2(robsz)]  completed entry index
//   wb_redir    in   [wbw]          completion requests redirect (mispredict or exception)
//   com_bundle  out  com_bundle_t[cwd]  commit/rollback bundle
// BEHAVIOUR
// - Reset (rst=0, async): head=tail=0, count=0, state=NORMAL, all entries invalid, com_bundle
//   register all-zero. rename=0 while rst=0.
// - Entry contents: opid, brid, lrda, prda[0] (old map), prda[1] (new preg), done, redir.
// - Pointers are log2(robsz)+1 bits; the wrap bit separates full from empty.
//   count = tail-head, range 0..robsz.
// - Accept (comb) in NORMAL:
//   - k = number of leading valid slots, capped at robsz-count.
//   - rename[i]=1 for i<k; a valid slot after an invalid one is never accepted.
//   - rob_idx[i] = tail+i; entries are written at the clock edge, done=0.
//   - Full (count=robsz): k=0.
// - Accept in WALK: rename[i]=opid[15] of slot i for every slot. Drained ops are discarded
//   without allocation. Accept in REDIR: rename=0.
// - Writeback: each wb_valid sets done[wb_idx] and ORs wb_redir into redir[wb_idx] at the edge.
//   Writebacks to invalid entries are ignored. Same-cycle writeback and commit of one entry:
//   the commit sees pre-edge done.
// - com_bundle is registered: decided in cycle N, presented in cycle N+1.
// - NORMAL commit:
//   - Retire oldest entries in order, up to cwd per cycle; stop at the first entry with done=0.
//   - Slot i: opid=entry opid, prda=entry prda, lrda, rollback=0, redir=0.
//   - Committing an entry with redir=1 and brid[7]=1: it is the last slot this cycle.
//     Its slot gets redir=1 with its brid, and slot 0 also carries redir=1 and that brid.
//     All younger entries are flushed (tail=head after the pop); stay in NORMAL.
//   - Entry at head with done=1, redir=1, brid[7]=0 (no snapshot): not retired; go to WALK
//     with walk_stop = that entry.
// - WALK:
//   - com_bundle[0].rollback=1 every cycle.
//   - The youngest up to cwd entries (tail-1, tail-2, ... down to and including walk_stop) fill
//     slots 0..n-1 with lrda, prda[0], prda[1], opid. Unused slots are all-zero.
//   - Advance: tail -= n only in cycles where ren_bundle[0].opid[15]=0 (rename queue drained).
//     Otherwise the same slots are re-presented.
//   - When tail reaches head, go to REDIR.
// - REDIR: one cycle with com_bundle[0].redir=1, brid[7]=0, all opid=0, rollback=0; then NORMAL.
// - Empty ROB: com_bundle all-zero (opid=0, prda=0) except the cases above.
// - Reset mid-WALK or mid-REDIR: immediate return to the reset state; no partial rollback
//   output after rst deasserts.
// TESTING
// - Accept/commit: 4 valid slots, count=0 -> rename=4'b1111, rob_idx 0..3. Complete all 4 ->
//   next edge commit decided; next cycle com_bundle has 4 slots with opid[15]=1 and matching
//   prda[0].
// - Full: robsz=32 filled, nothing done -> rename=0; complete head only -> exactly 1 commit,
//   then 1 slot accepted.
// - Gap stop: entries 0,1,3 done, 2 not -> commit 0,1 only; complete 2 -> 2,3 commit next.
// - Branch redirect: entry 5 of 10 has redir=1, brid=8'h83 -> commit up to 5 with slot
//   redir=1, brid=8'h83; count=0 after; no rollback.
// - Exception walk: 6 entries, head flagged, brid[7]=0, ren_bundle[0] valid for 2 cycles ->
//   rollback held 2 cycles, then slots 5..2, then 1..0, then one redir cycle, then NORMAL.
// - Wrap and reset: run 100 random ops through a 32-entry ROB -> in-order commit across wrap;
//   assert rst mid-WALK -> com_bundle=0 and count=0 immediately.

Source files
------------

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit, branch-snapshot flush and youngest-first rollback walk.
// com_bundle is registered one cycle after the decision; rename is throttled by free ROB entries.
package rob_pkg;
  typedef struct packed {
    logic [15:0]     opid;
    logic [7:0]      brid;
    logic [1:0][6:0] prda;
  } ren_bundle_t;

  typedef struct packed {
    logic [15:0]     opid;
    logic [7:0]      brid;
    logic [6:0]      lrda;
    logic [1:0][6:0] prda;
    logic            rollback;
    logic            redir;
  } com_bundle_t;
endpackage

module rob_commit
  import rob_pkg::*;
#(
  parameter int rwd   = 4,
  parameter int cwd   = 4,
  parameter int wbw   = 4,
  parameter int robsz = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  ren_bundle_t [rwd-1:0]                    ren_bundle,
  input  logic        [rwd-1:0][6:0]               ren_lrda,
  output logic        [rwd-1:0]                    rename,
  output logic        [rwd-1:0][$clog2(robsz)-1:0] rob_idx,
  input  logic        [wbw-1:0]                    wb_valid,
  input  logic        [wbw-1:0][$clog2(robsz)-1:0] wb_idx,
  input  logic        [wbw-1:0]                    wb_redir,
  output com_bundle_t [cwd-1:0]                    com_bundle
);
  localparam int aw = $clog2(robsz);
  localparam int pw = aw + 1;

  typedef enum logic [1:0] {NORMAL, WALK, REDIR} state_t;

  state_t                 state, state_nxt;
  logic [pw-1:0]          head, tail, head_nxt, tail_nxt, cnt, acc_n;
  com_bundle_t [cwd-1:0]  com_q, com_nxt;
  logic [robsz-1:0]       e_done, e_redir, done_nxt, redir_nxt;
  logic [15:0]            e_opid [robsz];
  logic [7:0]             e_brid [robsz];
  logic [6:0]             e_lrda [robsz];
  logic [1:0][6:0]        e_prda [robsz];

  assign cnt        = tail - head;
  assign com_bundle = com_q;

  // Occupancy is purely pointer based: entry valid iff (idx - head) < cnt.
  always_comb begin : accept_c
    logic          lead;
    logic [pw-1:0] room;
    rename = '0;
    acc_n  = '0;
    lead   = 1'b1;
    room   = pw'(robsz) - cnt;
    for (int i = 0; i < rwd; i++) begin
      rob_idx[i] = tail[aw-1:0] + aw'(i);
      case (state)
        NORMAL: begin
          lead      = lead && ren_bundle[i].opid[15] && (pw'(i) < room);
          rename[i] = lead;
          if (lead) acc_n = acc_n + pw'(1);
        end
        WALK:    rename[i] = ren_bundle[i].opid[15];
        default: rename[i] = 1'b0;
      endcase
    end
    if (!rst) rename = '0;
  end

  always_comb begin : wb_c
    logic [aw-1:0] off;
    done_nxt  = e_done;
    redir_nxt = e_redir;
    off       = '0;
    for (int j = 0; j < wbw; j++) begin
      off = wb_idx[j] - head[aw-1:0];
      if (wb_valid[j] && ({1'b0, off} < cnt)) begin
        done_nxt[wb_idx[j]]  = 1'b1;
        redir_nxt[wb_idx[j]] = redir_nxt[wb_idx[j]] | wb_redir[j];
      end
    end
    if (state == NORMAL) begin
      for (int i = 0; i < rwd; i++) begin
        if (rename[i]) begin
          done_nxt[rob_idx[i]]  = 1'b0;
          redir_nxt[rob_idx[i]] = 1'b0;
        end
      end
    end
  end

  always_comb begin : commit_c
    logic          stop;
    logic          flush;
    logic [aw-1:0] idx;
    logic [pw-1:0] walk_n;
    state_nxt = state;
    com_nxt   = '0;
    head_nxt  = head;
    tail_nxt  = tail;
    stop      = 1'b0;
    flush     = 1'b0;
    idx       = '0;
    walk_n    = '0;
    case (state)
      NORMAL: begin
        for (int i = 0; i < cwd; i++) begin
          idx = head[aw-1:0] + aw'(i);
          if (!stop) begin
            if ((pw'(i) >= cnt) || !e_done[idx]) begin
              stop = 1'b1;
            end else if (e_redir[idx] && !e_brid[idx][7]) begin
              // No snapshot: the faulting op stays at head and anchors the walk.
              stop = 1'b1;
              if (i == 0) state_nxt = WALK;
            end else begin
              com_nxt[i].opid = e_opid[idx];
              com_nxt[i].lrda = e_lrda[idx];
              com_nxt[i].prda = e_prda[idx];
              head_nxt        = head + pw'(i + 1);
              if (e_redir[idx]) begin
                com_nxt[i].redir = 1'b1;
                com_nxt[i].brid  = e_brid[idx];
                com_nxt[0].redir = 1'b1;
                com_nxt[0].brid  = e_brid[idx];
                flush            = 1'b1;
                stop             = 1'b1;
              end
            end
          end
        end
        tail_nxt = flush ? head_nxt : tail + acc_n;
      end
      WALK: begin
        for (int i = 0; i < cwd; i++) begin
          idx = tail[aw-1:0] - aw'(i + 1);
          if (pw'(i) < cnt) begin
            com_nxt[i].opid = e_opid[idx];
            com_nxt[i].lrda = e_lrda[idx];
            com_nxt[i].prda = e_prda[idx];
            walk_n          = pw'(i + 1);
          end
        end
        com_nxt[0].rollback = 1'b1;
        // Map-table restore must not race new renames: only advance once the queue is drained.
        if (!ren_bundle[0].opid[15]) begin
          tail_nxt = tail - walk_n;
          if (tail_nxt == head) state_nxt = REDIR;
        end
      end
      default: begin
        com_nxt[0].redir = 1'b1;
        state_nxt        = NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= NORMAL;
      head    <= '0;
      tail    <= '0;
      com_q   <= '0;
      e_done  <= '0;
      e_redir <= '0;
    end else begin
      state   <= state_nxt;
      head    <= head_nxt;
      tail    <= tail_nxt;
      com_q   <= com_nxt;
      e_done  <= done_nxt;
      e_redir <= redir_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < rwd; i++) begin
      if (state == NORMAL && rename[i]) begin
        e_opid[rob_idx[i]] <= ren_bundle[i].opid;
        e_brid[rob_idx[i]] <= ren_bundle[i].brid;
        e_prda[rob_idx[i]] <= ren_bundle[i].prda;
        e_lrda[rob_idx[i]] <= ren_lrda[i];
      end
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: accept-pattern table, directed corner sequences, and random traffic
// checked cycle by cycle against a queue-based ROB model.
module tb_rob_commit;
  import rob_pkg::*;

  logic                   clk, rst;
  ren_bundle_t [3:0]      ren;
  logic [3:0][6:0]        lrda;
  logic [3:0]             rename;
  logic [3:0][4:0]        rob_idx;
  logic [3:0]             wbv, wbr;
  logic [3:0][4:0]        wbi;
  com_bundle_t [3:0]      com_bundle;

  rob_commit dut (
    .clk(clk), .rst(rst), .ren_bundle(ren), .ren_lrda(lrda), .rename(rename),
    .rob_idx(rob_idx), .wb_valid(wbv), .wb_idx(wbi), .wb_redir(wbr), .com_bundle(com_bundle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_NORM, M_WALK, M_REDIR} mode_e;
  typedef struct {
    logic [15:0]     opid;
    logic [7:0]      brid;
    logic [6:0]      lrda;
    logic [1:0][6:0] prda;
    bit              done;
    bit              redir;
    int              idx;
  } m_ent_t;
  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_rename;
  } acc_vec_t;

  m_ent_t            q[$];
  int                head;
  mode_e             mode;
  com_bundle_t [3:0] exp_com;
  ren_bundle_t       sent[$];
  int                checks = 0;
  int                errors = 0;
  int                ctr = 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] m_rename();
    int k = 0;
    int room = 32 - q.size();
    if (mode == M_WALK) return {ren[3].opid[15], ren[2].opid[15], ren[1].opid[15], ren[0].opid[15]};
    if (mode == M_REDIR) return 4'b0;
    while (k < 4 && ren[k].opid[15]) k++;
    if (k > room) k = room;
    return 4'((1 << k) - 1);
  endfunction

  task automatic m_reset();
    q.delete();
    head = 0;
    mode = M_NORM;
    exp_com = '0;
  endtask

  task automatic m_edge();
    logic [3:0]        acc;
    com_bundle_t [3:0] nc;
    mode_e             m0;
    m_ent_t            e;
    bit                flush;
    int                n, w;
    acc = m_rename(); nc = '0; m0 = mode; flush = 0; n = 0; w = 0;
    if (m0 == M_NORM) begin
      while (n < 4 && q.size() > 0 && q[0].done) begin
        if (q[0].redir && !q[0].brid[7]) begin
          if (n == 0) mode = M_WALK;
          break;
        end
        nc[n].opid = q[0].opid; nc[n].lrda = q[0].lrda; nc[n].prda = q[0].prda;
        if (q[0].redir) begin
          nc[n].redir = 1'b1; nc[n].brid = q[0].brid;
          nc[0].redir = 1'b1; nc[0].brid = q[0].brid;
          flush = 1;
        end
        void'(q.pop_front());
        head = (head + 1) % 32;
        n++;
        if (flush) break;
      end
      if (flush) q.delete();
    end else if (m0 == M_WALK) begin
      w = (q.size() < 4) ? q.size() : 4;
      for (int i = 0; i < w; i++) begin
        e = q[q.size() - 1 - i];
        nc[i].opid = e.opid; nc[i].lrda = e.lrda; nc[i].prda = e.prda;
      end
      nc[0].rollback = 1'b1;
      if (!ren[0].opid[15]) begin
        repeat (w) void'(q.pop_back());
        if (q.size() == 0) mode = M_REDIR;
      end
    end else begin
      nc[0].redir = 1'b1;
      mode = M_NORM;
    end
    foreach (q[k])
      for (int j = 0; j < 4; j++)
        if (wbv[j] && int'(wbi[j]) == q[k].idx) begin
          q[k].done = 1;
          q[k].redir = q[k].redir | wbr[j];
        end
    if (m0 == M_NORM && !flush)
      for (int i = 0; i < 4; i++)
        if (acc[i]) begin
          e.opid = ren[i].opid; e.brid = ren[i].brid; e.lrda = lrda[i]; e.prda = ren[i].prda;
          e.done = 0; e.redir = 0; e.idx = (head + q.size()) % 32;
          q.push_back(e);
        end
    exp_com = nc;
  endtask

  task automatic step();
    logic [3:0] er;
    #1;
    er = m_rename();
    chk("rename", 256'(rename), 256'(er));
    for (int i = 0; i < 4; i++)
      if (er[i]) chk("rob_idx", 256'(rob_idx[i]), 256'((head + q.size() + i) % 32));
    chk("com_bundle", 256'(com_bundle), 256'(exp_com));
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic set_ren(input logic [3:0] mask, input bit rnd_brid);
    for (int i = 0; i < 4; i++) begin
      ren[i] = '0; lrda[i] = '0;
      if (mask[i]) begin
        ren[i].opid = {1'b1, 15'(ctr)};
        ctr++;
        ren[i].brid = rnd_brid ? 8'($urandom) : 8'h00;
        ren[i].prda = 14'($urandom);
        lrda[i] = 7'($urandom);
        sent.push_back(ren[i]);
      end
    end
  endtask

  task automatic clr_wb();
    wbv = '0; wbi = '0; wbr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ren = '0; lrda = '0;
    clr_wb();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    sent.delete();
  endtask

  initial begin
    acc_vec_t tbl[8];
    tbl[0] = '{4'b1111, 4'b1111}; tbl[1] = '{4'b0111, 4'b0111};
    tbl[2] = '{4'b1011, 4'b0011}; tbl[3] = '{4'b1101, 4'b0001};
    tbl[4] = '{4'b1110, 4'b0000}; tbl[5] = '{4'b0000, 4'b0000};
    tbl[6] = '{4'b0101, 4'b0001}; tbl[7] = '{4'b0011, 4'b0011};

    // Reset state, with valid rename slots offered while rst is low.
    rst = 1'b0; ren = '0; lrda = '0; clr_wb();
    repeat (2) @(negedge clk);
    set_ren(4'hf, 0);
    #1;
    chk("rst_rename", 256'(rename), 256'(0));
    chk("rst_com", 256'(com_bundle), 256'(0));
    do_reset();

    // Accept-pattern table on an empty ROB (inputs withdrawn before the edge).
    foreach (tbl[t]) begin
      @(negedge clk);
      set_ren(tbl[t].valid, 0);
      #1;
      chk("acc_tbl", 256'(rename), 256'(tbl[t].exp_rename));
      #1;
      ren = '0;
    end
    do_reset();

    // Accept 4, complete 4, commit 4.
    set_ren(4'hf, 0);
    #1;
    chk("acc4_rename", 256'(rename), 256'(4'b1111));
    chk("acc4_idx", 256'(rob_idx), 256'({5'd3, 5'd2, 5'd1, 5'd0}));
    step();
    ren = '0; wbv = 4'hf; wbi = {5'd3, 5'd2, 5'd1, 5'd0};
    step();
    clr_wb();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("com4_vld", 256'(com_bundle[i].opid[15]), 256'(1));
      chk("com4_prda0", 256'(com_bundle[i].prda[0]), 256'(sent[i].prda[0]));
    end
    step();

    // Full ROB, then one commit frees exactly one slot.
    do_reset();
    for (int s = 0; s < 8; s++) begin set_ren(4'hf, 0); step(); end
    set_ren(4'hf, 0);
    #1;
    chk("full_rename", 256'(rename), 256'(0));
    wbv = 4'b0001; wbi = '0;
    step();
    clr_wb();
    step();
    #1;
    chk("full_one_acc", 256'(rename), 256'(4'b0001));
    chk("full_com0", 256'(com_bundle[0].opid), 256'(sent[0].opid));
    chk("full_com1", 256'(com_bundle[1].opid), 256'(0));
    step();
    ren = '0;
    step();

    // Gap stop: 0,1,3 done, 2 pending.
    do_reset();
    set_ren(4'hf, 0); step();
    ren = '0; wbv = 4'b0111; wbi = {5'd0, 5'd3, 5'd1, 5'd0};
    step();
    wbv = 4'b0001; wbi = {5'd0, 5'd0, 5'd0, 5'd2};
    step();
    chk("gap_com1", 256'(com_bundle[1].opid), 256'(sent[1].opid));
    chk("gap_com2", 256'(com_bundle[2].opid), 256'(0));
    clr_wb();
    step();
    chk("gap_com_e2", 256'(com_bundle[0].opid), 256'(sent[2].opid));
    chk("gap_com_e3", 256'(com_bundle[1].opid), 256'(sent[3].opid));
    step();

    // Branch redirect with snapshot at entry 5 of 10.
    do_reset();
    set_ren(4'hf, 0); step();
    set_ren(4'hf, 0); ren[1].brid = 8'h83; sent[5].brid = 8'h83;
    wbv = 4'hf; wbi = {5'd3, 5'd2, 5'd1, 5'd0};
    step();
    set_ren(4'b0011, 0);
    wbi = {5'd7, 5'd6, 5'd5, 5'd4}; wbr = 4'b0010;
    step();
    ren = '0; wbv = 4'b0011; wbi = {5'd0, 5'd0, 5'd9, 5'd8}; wbr = '0;
    step();
    chk("br_s0_redir", 256'({com_bundle[0].redir, com_bundle[0].brid}), 256'({1'b1, 8'h83}));
    chk("br_s1_redir", 256'({com_bundle[1].redir, com_bundle[1].brid}), 256'({1'b1, 8'h83}));
    chk("br_s1_opid", 256'(com_bundle[1].opid), 256'(sent[5].opid));
    chk("br_s2_zero", 256'(com_bundle[2]), 256'(0));
    chk("br_no_rb", 256'(com_bundle[0].rollback), 256'(0));
    clr_wb();
    set_ren(4'hf, 0);
    #1;
    chk("br_empty_acc", 256'(rename), 256'(4'b1111));
    chk("br_tail", 256'(rob_idx[0]), 256'(6));
    step();

    // Exception walk over 6 entries, held 2 cycles by a non-drained rename queue.
    do_reset();
    set_ren(4'hf, 0); step();
    set_ren(4'b0011, 0); step();
    ren = '0; wbv = 4'b0001; wbi = '0; wbr = 4'b0001;
    step();
    clr_wb();
    step();
    set_ren(4'b0101, 0);
    #1;
    chk("walk_discard", 256'(rename), 256'(4'b0101));
    for (int h = 0; h < 3; h++) begin
      if (h == 2) ren = '0;
      step();
      chk("walk_rb", 256'(com_bundle[0].rollback), 256'(1));
      chk("walk_s0", 256'(com_bundle[0].opid), 256'(sent[5].opid));
      chk("walk_s3", 256'(com_bundle[3].opid), 256'(sent[2].opid));
    end
    step();
    chk("walk_t0", 256'(com_bundle[0].opid), 256'(sent[1].opid));
    chk("walk_t1", 256'(com_bundle[1].opid), 256'(sent[0].opid));
    chk("walk_t2", 256'(com_bundle[2]), 256'(0));
    step();
    chk("walk_redir", 256'({com_bundle[0].redir, com_bundle[0].rollback, com_bundle[0].brid}),
        256'({1'b1, 1'b0, 8'h00}));
    step();
    step();

    // Reset asserted in the middle of a walk.
    do_reset();
    set_ren(4'hf, 0); step();
    ren = '0; wbv = 4'b0001; wbi = '0; wbr = 4'b0001;
    step();
    clr_wb();
    step();
    set_ren(4'b0001, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rstwalk_com", 256'(com_bundle), 256'(0));
    chk("rstwalk_rename", 256'(rename), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    set_ren(4'hf, 0);
    #1;
    chk("rstwalk_acc", 256'(rename), 256'(4'b1111));
    chk("rstwalk_idx", 256'(rob_idx[0]), 256'(0));
    step();
    ren = '0;
    step();

    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 900; c++) begin
      set_ren(($urandom_range(0, 1) == 1) ? 4'hf : 4'($urandom_range(0, 15)), 1);
      clr_wb();
      for (int j = 0; j < 4; j++) begin
        if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
          int k = $urandom_range(0, q.size() - 1);
          wbv[j] = 1'b1;
          wbi[j] = 5'(q[k].idx);
          wbr[j] = ($urandom_range(0, 40) == 0);
        end else if ($urandom_range(0, 9) == 0) begin
          wbv[j] = 1'b1;
          wbi[j] = 5'($urandom_range(0, 31));
        end
      end
      step();
    end
    ren = '0; clr_wb();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
